// File: rtl/pwm_pkg.sv
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared constants, counter-direction type and byte-masked merge.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int ADDR_PERIOD = 0;
  localparam int BE_MAX_W    = 16;
  localparam int DATA_MAX_W  = 8 * BE_MAX_W;

  typedef enum logic [0:0] {
    UP   = 1'b0,
    DOWN = 1'b1
  } cnt_dir_e;

  // Callers zero-extend into the wide container and truncate the result back to N bits.
  function automatic logic [DATA_MAX_W-1:0] be_merge(
    input logic [DATA_MAX_W-1:0] old_v,
    input logic [DATA_MAX_W-1:0] new_v,
    input logic [BE_MAX_W-1:0]   be
  );
    logic [DATA_MAX_W-1:0] res;
    res = old_v;
    for (int k = 0; k < BE_MAX_W; k++) begin
      if (be[k]) res[8*k +: 8] = new_v[8*k +: 8];
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_multi_core_if.sv
// ============================================================================
// Module  : pwm_multi_core_if
// Brief   : Register-write and PWM-output bundle; center port under PWM_CENTER_ALIGN_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pwm_multi_core_if #(
  parameter int N      = 16,
  parameter int CH     = 4,
  parameter int BE_W   = (N + 7) / 8,
  parameter int ADDR_W = $clog2(CH + 1)
);

  logic              enable;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [N-1:0]      wr_data;
  logic [BE_W-1:0]   byteenable;
`ifdef PWM_CENTER_ALIGN_EN
  logic              center;
`endif
  logic [CH-1:0]     out;
  logic              period_end;

  modport master (
    output enable, wr_en, wr_addr, wr_data, byteenable,
`ifdef PWM_CENTER_ALIGN_EN
           center,
`endif
    input  out, period_end
  );

  modport slave (
    input  enable, wr_en, wr_addr, wr_data, byteenable,
`ifdef PWM_CENTER_ALIGN_EN
           center,
`endif
    output out, period_end
  );

endinterface

`default_nettype wire

// File: rtl/pwm_compare_ch.sv
// ============================================================================
// Module  : pwm_compare_ch
// Brief   : One PWM channel: shadow duty, active duty and registered compare.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_compare_ch
  import pwm_pkg::*;
#(
  parameter int N    = 16,
  parameter int BE_W = (N + 7) / 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_i,
  input  logic [N-1:0]    wr_data_i,
  input  logic [BE_W-1:0] be_i,
  input  logic            load_i,
  input  logic            run_i,
  input  logic [N-1:0]    cnt_i,
  output logic            out_o
);

  logic [N-1:0] duty_sh_q, duty_sh_d;
  logic [N-1:0] duty_act_q, duty_act_d;
  logic         out_q, out_d;

  always_comb begin
    duty_sh_d = duty_sh_q;
    if (wr_i) begin
      duty_sh_d = N'(be_merge(DATA_MAX_W'(duty_sh_q), DATA_MAX_W'(wr_data_i),
                              BE_MAX_W'(be_i)));
    end
    // Load samples the pre-write shadow, so a write on the boundary waits a period.
    duty_act_d = load_i ? duty_sh_q : duty_act_q;
    out_d      = run_i && (cnt_i <= duty_act_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh_q  <= '0;
      duty_act_q <= '0;
      out_q      <= 1'b0;
    end else begin
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      out_q      <= out_d;
    end
  end

  assign out_o = out_q;

endmodule

`default_nettype wire

// File: rtl/pwm_multi_core.sv
// ============================================================================
// Module  : pwm_multi_core
// Brief   : Shared period counter, period registers and CH duty comparators.
//           Define PWM_CENTER_ALIGN_EN for the triangle (center-aligned) mode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm_multi_core
  import pwm_pkg::*;
#(
  parameter int N    = 16,
  parameter int CH   = 4,
  parameter int BE_W = (N + 7) / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_multi_core_if.slave  bus
);

  localparam int ADDR_W = $clog2(CH + 1);

  logic [N-1:0]  cnt_q, cnt_d;
  logic [N-1:0]  per_sh_q, per_sh_d;
  logic [N-1:0]  per_act_q, per_act_d;
  logic          pe_q, pe_d;
  logic          load, run, wr_per;
  logic [CH-1:0] ch_wr;
  logic [CH-1:0] ch_out;
`ifdef PWM_CENTER_ALIGN_EN
  cnt_dir_e      dir_q, dir_d;
  logic          ctr_q, ctr_d;
  logic          going_down;
`endif

  always_comb begin
    run      = bus.enable && (per_act_q != '0);
    wr_per   = bus.wr_en && (bus.wr_addr == ADDR_W'(ADDR_PERIOD));
    per_sh_d = per_sh_q;
    if (wr_per) begin
      per_sh_d = N'(be_merge(DATA_MAX_W'(per_sh_q), DATA_MAX_W'(bus.wr_data),
                             BE_MAX_W'(bus.byteenable)));
    end
    cnt_d = cnt_q + N'(1);
    load  = 1'b0;
    pe_d  = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
    dir_d      = dir_q;
    ctr_d      = ctr_q;
    going_down = (dir_q == DOWN) || (cnt_q == per_act_q);
    if (ctr_q) begin
      // Boundary is the edge that brings the down-count back to 1.
      if (!run || (per_act_q < N'(2))) begin
        load  = 1'b1;
        cnt_d = N'(1);
        pe_d  = run;
      end else if (going_down && (cnt_q == N'(2))) begin
        load  = 1'b1;
        cnt_d = N'(1);
        pe_d  = 1'b1;
      end else if (going_down) begin
        cnt_d = cnt_q - N'(1);
        dir_d = DOWN;
      end
    end else
`endif
    begin
      if (!run || (cnt_q == per_act_q)) begin
        load  = 1'b1;
        cnt_d = N'(1);
      end
      pe_d = run && (cnt_q == per_act_q);
    end
`ifdef PWM_CENTER_ALIGN_EN
    if (load) begin
      dir_d = UP;
      ctr_d = bus.center;
    end
`endif
    per_act_d = load ? per_sh_q : per_act_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= N'(1);
      per_sh_q  <= '0;
      per_act_q <= '0;
      pe_q      <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q     <= UP;
      ctr_q     <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      per_sh_q  <= per_sh_d;
      per_act_q <= per_act_d;
      pe_q      <= pe_d;
`ifdef PWM_CENTER_ALIGN_EN
      dir_q     <= dir_d;
      ctr_q     <= ctr_d;
`endif
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign ch_wr[c] = bus.wr_en && (bus.wr_addr == ADDR_W'(c + 1));

    pwm_compare_ch #(
      .N    (N),
      .BE_W (BE_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_i      (ch_wr[c]),
      .wr_data_i (bus.wr_data),
      .be_i      (bus.byteenable),
      .load_i    (load),
      .run_i     (run),
      .cnt_i     (cnt_q),
      .out_o     (ch_out[c])
    );
  end

  assign bus.out        = ch_out;
  assign bus.period_end = pe_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi_core.sv
// ============================================================================
// Module  : tb_pwm_multi_core
// Brief   : Directed vector table plus reset and full-width wrap sequences.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pwm_multi_core;

  localparam int N  = 16;
  localparam int CH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_multi_core_if #(.N(N), .CH(CH)) bus ();

  pwm_multi_core #(.N(N), .CH(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        en;
    logic        we;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [3:0]  exp_out;
    logic        exp_pe;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic en, input logic we, input logic [2:0] addr,
                         input logic [15:0] data, input logic [1:0] be,
                         input logic [3:0] exp_out, input logic exp_pe);
    vec_t v;
    v.en = en; v.we = we; v.addr = addr; v.data = data; v.be = be;
    v.exp_out = exp_out; v.exp_pe = exp_pe;
    vecs.push_back(v);
  endtask

  // Period-10 rows: ch0 high for counter <= w, ch1/ch3 low, ch2 high; optional duty0 write at row wr_k.
  task automatic add_period(input int w, input int wr_k, input logic [15:0] wr_d, input int rows);
    for (int k = 1; k <= rows; k++) begin
      add_vec(1'b1, k == wr_k, 3'd1, wr_d, 2'b11,
              {1'b0, 1'b1, 1'b0, k <= w}, k == 10);
    end
  endtask

  task automatic drive(input logic en, input logic we, input logic [2:0] addr,
                       input logic [15:0] data, input logic [1:0] be);
    bus.enable     = en;
    bus.wr_en      = we;
    bus.wr_addr    = addr;
    bus.wr_data    = data;
    bus.byteenable = be;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int hi;
    logic got;
`ifdef PWM_CENTER_ALIGN_EN
    bus.center = 1'b0;
`endif
    drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    repeat (3) step();
    check("reset_state", {bus.out, bus.period_end}, 5'b0);
    rst_n = 1'b1;

    // Idle with period 0, then configuration while disabled.
    add_vec(1, 0, 3'd0, 16'h0000, 2'b00, 4'b0000, 0);
    add_vec(1, 0, 3'd0, 16'h0000, 2'b00, 4'b0000, 0);
    add_vec(0, 1, 3'd0, 16'd10,   2'b11, 4'b0000, 0);
    add_vec(0, 1, 3'd1, 16'd3,    2'b11, 4'b0000, 0);
    add_vec(0, 1, 3'd5, 16'hFFFF, 2'b11, 4'b0000, 0);
    add_vec(0, 1, 3'd2, 16'd0,    2'b11, 4'b0000, 0);
    add_vec(0, 1, 3'd3, 16'd10,   2'b11, 4'b0000, 0);
    add_vec(0, 1, 3'd4, 16'hFFFF, 2'b00, 4'b0000, 0);
    add_vec(0, 0, 3'd0, 16'h0000, 2'b00, 4'b0000, 0);
    add_period(3, 0,  16'd0, 10);
    add_period(3, 5,  16'd7, 10);
    add_period(7, 10, 16'd2, 10);
    add_period(7, 0,  16'd0, 10);
    add_period(2, 0,  16'd0, 4);
    add_vec(0, 0, 3'd0, 16'h0000, 2'b00, 4'b0000, 0);
    add_vec(0, 0, 3'd0, 16'h0000, 2'b00, 4'b0000, 0);
    add_period(2, 0,  16'd0, 10);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].be);
      step();
      check($sformatf("vec%0d", i), {bus.out, bus.period_end},
            {vecs[i].exp_out, vecs[i].exp_pe});
    end

    // Last vector left out[2] and period_end high; reset must clear them without a clock edge.
    #2 rst_n = 1'b0;
    #1 check("async_reset", {bus.out, bus.period_end}, 5'b0);
    step();
    step();
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 3'd0, 16'h0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("lost_shadow%0d", i), {bus.out, bus.period_end}, 5'b0);
    end

    // Full-width period with a byte-masked duty update: 8000 then low byte AA -> 80AA.
    drive(1'b0, 1'b1, 3'd0, 16'hFFFF, 2'b11); step();
    drive(1'b0, 1'b1, 3'd1, 16'h8000, 2'b11); step();
    drive(1'b0, 1'b1, 3'd1, 16'h00AA, 2'b01); step();
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 2'b00); step();
    step();
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 2'b00);
    n   = 0;
    hi  = 0;
    got = 1'b0;
    while (n < 70000 && !got) begin
      step();
      n++;
      if (bus.out[0]) hi++;
      if (bus.period_end) got = 1'b1;
    end
    check("ffff_period_len", n, 65535);
    check("ffff_high_cnt", hi, 32938);
    step();
    check("ffff_wrap", {bus.out[0], bus.period_end}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
